// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/forwarding/flush controller for a 5-stage pipeline; controls and operand muxes are same-cycle combinational.
// Backpressure: a multi-cycle load in MEM freezes every stage; a load-use hazard holds PC and IF/ID for one cycle.
module pipeline_hazard_ctrl #(
    parameter int XLEN    = 64,
    parameter int REG_AW  = 5,
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              ex_branch_taken,
    input  logic [XLEN-1:0]   ex_rs1_data,
    input  logic [XLEN-1:0]   ex_rs2_data,
    input  logic [XLEN-1:0]   mem_fwd_data,
    input  logic [XLEN-1:0]   wb_fwd_data,
    output logic [XLEN-1:0]   ex_op_a,
    output logic [XLEN-1:0]   ex_op_b,
    output logic [1:0]        forward_a,
    output logic [1:0]        forward_b,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              stage_en,
    output logic              id_ex_bubble,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic              wb_bubble,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  flush_count
);

    localparam logic [1:0] LAT_LAST = 2'(MEM_LAT - 1);

    logic              ex_v, ex_regwrite, ex_load;
    logic [REG_AW-1:0] ex_rd, ex_rs1, ex_rs2;
    logic              mem_v, mem_regwrite, mem_load;
    logic [REG_AW-1:0] mem_rd;
    logic              wb_v, wb_regwrite;
    logic [REG_AW-1:0] wb_rd;
    logic [1:0]        lat_cnt;

    logic mem_busy, branch_flush, load_use;
    logic mem_fwd_ok, wb_fwd_ok;

    always_comb begin
        mem_busy     = mem_v & mem_load & (lat_cnt != LAT_LAST);
        branch_flush = ~mem_busy & ex_branch_taken & ex_v;
        load_use     = ~mem_busy & ~branch_flush & id_valid & ex_v & ex_load
                     & (ex_rd != '0)
                     & ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

        pc_write     = ~mem_busy & ~load_use;
        if_id_write  = ~mem_busy & ~load_use;
        stage_en     = ~mem_busy;
        id_ex_bubble = load_use;
        if_id_flush  = branch_flush;
        id_ex_flush  = branch_flush;
        wb_bubble    = mem_busy;
    end

    // A load still in MEM has no result yet, so only non-load MEM producers forward.
    assign mem_fwd_ok = mem_v & mem_regwrite & ~mem_load & (mem_rd != '0);
    assign wb_fwd_ok  = wb_v & wb_regwrite & (wb_rd != '0);

    assign forward_a = (mem_fwd_ok && (mem_rd == ex_rs1)) ? 2'b10 :
                       (wb_fwd_ok  && (wb_rd  == ex_rs1)) ? 2'b01 : 2'b00;
    assign forward_b = (mem_fwd_ok && (mem_rd == ex_rs2)) ? 2'b10 :
                       (wb_fwd_ok  && (wb_rd  == ex_rs2)) ? 2'b01 : 2'b00;

    always_comb begin
        case (forward_a)
            2'b10:   ex_op_a = mem_fwd_data;
            2'b01:   ex_op_a = wb_fwd_data;
            default: ex_op_a = ex_rs1_data;
        endcase
        case (forward_b)
            2'b10:   ex_op_b = mem_fwd_data;
            2'b01:   ex_op_b = wb_fwd_data;
            default: ex_op_b = ex_rs2_data;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ex_v         <= 1'b0;
            ex_regwrite  <= 1'b0;
            ex_load      <= 1'b0;
            ex_rd        <= '0;
            ex_rs1       <= '0;
            ex_rs2       <= '0;
            mem_v        <= 1'b0;
            mem_regwrite <= 1'b0;
            mem_load     <= 1'b0;
            mem_rd       <= '0;
            wb_v         <= 1'b0;
            wb_regwrite  <= 1'b0;
            wb_rd        <= '0;
            lat_cnt      <= 2'd0;
            stall_count  <= '0;
            flush_count  <= '0;
        end else begin
            if (stage_en) begin
                wb_v         <= mem_v;
                wb_regwrite  <= mem_regwrite;
                wb_rd        <= mem_rd;
                mem_v        <= ex_v;
                mem_regwrite <= ex_regwrite;
                mem_load     <= ex_load;
                mem_rd       <= ex_rd;
                ex_v         <= id_valid & ~load_use & ~branch_flush;
                ex_regwrite  <= id_regwrite;
                ex_load      <= id_memread;
                ex_rd        <= id_rd;
                ex_rs1       <= id_rs1;
                ex_rs2       <= id_rs2;
                lat_cnt      <= 2'd0;
            end else begin
                lat_cnt      <= lat_cnt + 2'd1;
            end

            if ((mem_busy | load_use) && (stall_count != {CNT_W{1'b1}}))
                stall_count <= stall_count + CNT_W'(1);
            if (branch_flush && (flush_count != {CNT_W{1'b1}}))
                flush_count <= flush_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Two controller instances (single-cycle MEM with wide counters, 3-cycle MEM with 2-bit counters) share stimulus;
// an instruction-level pipeline model predicts each cycle's outputs into per-instance queues drained by a monitor.
module tb_pipeline_hazard_ctrl;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        id_valid = 1'b0;
    logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic        id_use_rs1 = 1'b0, id_use_rs2 = 1'b0, id_regwrite = 1'b0, id_memread = 1'b0;
    logic        ex_branch_taken = 1'b0;
    logic [63:0] ex_rs1_data = '0, ex_rs2_data = '0, mem_fwd_data = '0, wb_fwd_data = '0;

    logic [63:0] a_op_a, a_op_b, b_op_a, b_op_b;
    logic [1:0]  a_fa, a_fb, b_fa, b_fb;
    logic        a_pcw, a_ifw, a_sen, a_bub, a_iff, a_ief, a_wbb;
    logic        b_pcw, b_ifw, b_sen, b_bub, b_iff, b_ief, b_wbb;
    logic [31:0] a_sc, a_fc;
    logic [1:0]  b_sc, b_fc;

    always #5 clock = ~clock;

    pipeline_hazard_ctrl #(.XLEN(64), .REG_AW(5), .MEM_LAT(1), .CNT_W(32)) dut_a (
        .clock(clock), .reset_n(reset_n), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_regwrite(id_regwrite), .id_memread(id_memread),
        .ex_branch_taken(ex_branch_taken),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
        .mem_fwd_data(mem_fwd_data), .wb_fwd_data(wb_fwd_data),
        .ex_op_a(a_op_a), .ex_op_b(a_op_b), .forward_a(a_fa), .forward_b(a_fb),
        .pc_write(a_pcw), .if_id_write(a_ifw), .stage_en(a_sen), .id_ex_bubble(a_bub),
        .if_id_flush(a_iff), .id_ex_flush(a_ief), .wb_bubble(a_wbb),
        .stall_count(a_sc), .flush_count(a_fc)
    );

    pipeline_hazard_ctrl #(.XLEN(64), .REG_AW(5), .MEM_LAT(3), .CNT_W(2)) dut_b (
        .clock(clock), .reset_n(reset_n), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_regwrite(id_regwrite), .id_memread(id_memread),
        .ex_branch_taken(ex_branch_taken),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
        .mem_fwd_data(mem_fwd_data), .wb_fwd_data(wb_fwd_data),
        .ex_op_a(b_op_a), .ex_op_b(b_op_b), .forward_a(b_fa), .forward_b(b_fb),
        .pc_write(b_pcw), .if_id_write(b_ifw), .stage_en(b_sen), .id_ex_bubble(b_bub),
        .if_id_flush(b_iff), .id_ex_flush(b_ief), .wb_bubble(b_wbb),
        .stall_count(b_sc), .flush_count(b_fc)
    );

    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       rw;
        logic       ld;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
    } ins_t;

    // ctrl = {pc_write, if_id_write, stage_en, id_ex_bubble, if_id_flush, id_ex_flush, wb_bubble}
    typedef struct packed {
        logic [6:0]   ctrl;
        logic [3:0]   fwd;
        logic [127:0] ops;
        logic [31:0]  sc;
        logic [31:0]  fc;
    } obs_t;

    ins_t   m_ex[2], m_mem[2], m_wb[2];
    int     m_age[2];
    longint m_st[2], m_fl[2];
    obs_t   q0[$], q1[$];
    int     checks = 0;
    int     failures = 0;

    function automatic logic [1:0] src_of(int i, logic [4:0] rs);
        if (m_mem[i].v && m_mem[i].rw && !m_mem[i].ld && m_mem[i].rd != 5'd0 && m_mem[i].rd == rs)
            return 2'b10;
        if (m_wb[i].v && m_wb[i].rw && m_wb[i].rd != 5'd0 && m_wb[i].rd == rs)
            return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [63:0] pick(logic [1:0] s, logic [63:0] regval);
        if (s == 2'b10) return mem_fwd_data;
        if (s == 2'b01) return wb_fwd_data;
        return regval;
    endfunction

    task automatic model_cycle(int i);
        int     lat;
        longint cap;
        logic   frozen, br, lu;
        logic [1:0] fa, fb;
        obs_t   e;
        lat = (i == 0) ? 1 : 3;
        cap = (i == 0) ? 64'hFFFF_FFFF : 64'd3;
        if (!reset_n) begin
            m_ex[i] = '0; m_mem[i] = '0; m_wb[i] = '0;
            m_age[i] = 0; m_st[i] = 0; m_fl[i] = 0;
        end
        frozen = m_mem[i].v && m_mem[i].ld && (m_age[i] < lat - 1);
        br = !frozen && ex_branch_taken && m_ex[i].v;
        lu = !frozen && !br && id_valid && m_ex[i].v && m_ex[i].ld && m_ex[i].rd != 5'd0 &&
             ((id_use_rs1 && id_rs1 == m_ex[i].rd) || (id_use_rs2 && id_rs2 == m_ex[i].rd));
        fa = src_of(i, m_ex[i].rs1);
        fb = src_of(i, m_ex[i].rs2);
        e.ctrl = {!frozen && !lu, !frozen && !lu, !frozen, lu, br, br, frozen};
        e.fwd  = {fa, fb};
        e.ops  = {pick(fa, ex_rs1_data), pick(fb, ex_rs2_data)};
        e.sc   = 32'((m_st[i] > cap) ? cap : m_st[i]);
        e.fc   = 32'((m_fl[i] > cap) ? cap : m_fl[i]);
        if (m_ex[i].v && m_mem[i].v && m_mem[i].ld && m_mem[i].rd != 5'd0 &&
            ((m_ex[i].u1 && m_ex[i].rs1 == m_mem[i].rd) || (m_ex[i].u2 && m_ex[i].rs2 == m_mem[i].rd))) begin
            failures++;
            $display("FAIL inst%0d mem_load_feeds_ex t=%0t got=reachable want=unreachable", i, $time);
        end
        if (i == 0) q0.push_back(e); else q1.push_back(e);
        if (reset_n) begin
            if (frozen) begin
                m_age[i]++;
                m_st[i]++;
            end else begin
                m_wb[i]  = m_mem[i];
                m_mem[i] = m_ex[i];
                m_ex[i]  = '{v: id_valid && !lu && !br, rd: id_rd, rw: id_regwrite, ld: id_memread,
                             rs1: id_rs1, rs2: id_rs2, u1: id_use_rs1, u2: id_use_rs2};
                m_age[i] = 0;
                if (lu) m_st[i]++;
                if (br) m_fl[i]++;
            end
        end
    endtask

    task automatic chk(int i, string nm, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL inst%0d %s t=%0t got=%h want=%h", i, nm, $time, act, exp);
        end
    endtask

    task automatic compare(int i, obs_t a, obs_t e);
        chk(i, "ctrl",        128'(a.ctrl), 128'(e.ctrl));
        chk(i, "forward",     128'(a.fwd),  128'(e.fwd));
        chk(i, "operands",    a.ops,        e.ops);
        chk(i, "stall_count", 128'(a.sc),   128'(e.sc));
        chk(i, "flush_count", 128'(a.fc),   128'(e.fc));
    endtask

    always @(negedge clock) begin
        obs_t e, a;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            a.ctrl = {a_pcw, a_ifw, a_sen, a_bub, a_iff, a_ief, a_wbb};
            a.fwd  = {a_fa, a_fb};
            a.ops  = {a_op_a, a_op_b};
            a.sc   = a_sc;
            a.fc   = a_fc;
            compare(0, a, e);
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            a.ctrl = {b_pcw, b_ifw, b_sen, b_bub, b_iff, b_ief, b_wbb};
            a.fwd  = {b_fa, b_fb};
            a.ops  = {b_op_a, b_op_b};
            a.sc   = {30'd0, b_sc};
            a.fc   = {30'd0, b_fc};
            compare(1, a, e);
        end
    end

    task automatic issue(logic rn, logic v, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
                         logic u1, logic u2, logic rw, logic ld, logic br);
        @(posedge clock);
        #1;
        reset_n = rn;
        id_valid = v; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
        id_use_rs1 = u1; id_use_rs2 = u2; id_regwrite = rw; id_memread = ld;
        ex_branch_taken = br;
        ex_rs1_data  = {$urandom, $urandom};
        ex_rs2_data  = {$urandom, $urandom};
        mem_fwd_data = {$urandom, $urandom};
        wb_fwd_data  = {$urandom, $urandom};
        model_cycle(0);
        model_cycle(1);
    endtask

    task automatic nop(int n);
        for (int k = 0; k < n; k++) issue(1, 1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #2 reset_n = 1'b0;
        for (int k = 0; k < 3; k++) issue(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
        nop(2);
        // add x5,x1,x2 ; sub x6,x5,x3 ; or x7,x5,x4
        issue(1, 1, 5'd5, 5'd1, 5'd2, 1, 1, 1, 0, 0);
        issue(1, 1, 5'd6, 5'd5, 5'd3, 1, 1, 1, 0, 0);
        issue(1, 1, 5'd7, 5'd5, 5'd4, 1, 1, 1, 0, 0);
        nop(4);
        // ld x6,8(x0) ; add x7,x6,x1 held in ID across the stall
        issue(1, 1, 5'd6, 5'd0, 5'd0, 1, 0, 1, 1, 0);
        issue(1, 1, 5'd7, 5'd6, 5'd1, 1, 1, 1, 0, 0);
        issue(1, 1, 5'd7, 5'd6, 5'd1, 1, 1, 1, 0, 0);
        nop(6);
        // taken branch resolves in EX
        issue(1, 1, 5'd0, 5'd1, 5'd2, 1, 1, 0, 0, 0);
        issue(1, 1, 5'd3, 5'd1, 5'd2, 1, 1, 1, 0, 1);
        nop(3);
        // write x0 then read x0
        issue(1, 1, 5'd0, 5'd1, 5'd2, 1, 1, 1, 0, 0);
        issue(1, 1, 5'd8, 5'd0, 5'd0, 1, 1, 1, 0, 0);
        nop(3);
        // load freezes MEM while a taken branch waits in EX
        issue(1, 1, 5'd9, 5'd0, 5'd0, 1, 0, 1, 1, 0);
        issue(1, 1, 5'd0, 5'd1, 5'd1, 1, 1, 0, 0, 0);
        for (int k = 0; k < 3; k++) issue(1, 1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1);
        nop(4);
        // reset lands in the middle of a freeze
        issue(1, 1, 5'd9, 5'd0, 5'd0, 1, 0, 1, 1, 0);
        nop(2);
        issue(0, 1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
        nop(3);
        for (int k = 0; k < 3000; k++) begin
            issue(($urandom_range(0, 499) != 0),
                  ($urandom_range(0, 9) != 0),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 7) == 0));
        end
        nop(1);
        @(negedge clock);
        @(negedge clock);
        checks++;
        if (q0.size() + q1.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d pending want=0", q0.size() + q1.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Parametrised hazard, forwarding and flush controller for the 5-stage RISC-V pipeline. It keeps its own valid-tagged shadow of the EX, MEM and WB stage destinations and generates PC, IF/ID and stage-enable controls, bubble and flush strobes, and the EX operand forwarding muxes. Compared with the single-cycle-memory hazard/forwarding pair, it adds:
- branch flush;
- multi-cycle load latency (pipeline freeze);
- x0 suppression;
- saturating hazard statistics.

## Interface
Parameters:
- XLEN, 64, datapath width of forwarded operands
- REG_AW, 5, register address width
- MEM_LAT, 1, cycles a load occupies MEM (1..4)
- CNT_W, 32, statistics counter width

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rs1, id_rs2, id_rd  in  REG_AW  ID source/destination addresses
- id_use_rs1, id_use_rs2  in  1  ID instruction reads rs1/rs2
- id_regwrite, id_memread  in  1  ID writes rd / is a load
- ex_branch_taken  in  1  branch in EX resolved taken
- ex_rs1_data, ex_rs2_data  in  XLEN  ID/EX register operands
- mem_fwd_data  in  XLEN  EX/MEM ALU result
- wb_fwd_data  in  XLEN  MEM/WB write-back value
- ex_op_a, ex_op_b  out  XLEN  forwarded EX operands
- forward_a, forward_b  out  2  00 = register, 10 = MEM, 01 = WB
- pc_write, if_id_write  out  1  PC / IF/ID load enables
- stage_en  out  1  ID/EX, EX/MEM, MEM/WB advance enable
- id_ex_bubble  out  1  load zeros into ID/EX controls
- if_id_flush, id_ex_flush  out  1  squash IF/ID, ID/EX contents
- wb_bubble  out  1  MEM/WB regwrite forced 0 this cycle
- stall_count, flush_count  out  CNT_W  saturating hazard counts

## Operation
Shadow state: per stage (EX, MEM, WB) v, rd, regwrite, load; EX also holds rs1/rs2/use flags. Plus lat_cnt (2 bits).

Control outputs are combinational from shadow state and ID inputs, evaluated in this priority order:

1. **Freeze**
   - mem_busy = mem_v & mem_load & (lat_cnt != MEM_LAT-1).
   - When mem_busy: stage_en=0, pc_write=0, if_id_write=0, both flushes 0, wb_bubble=1.
   - lat_cnt increments each busy cycle and clears when MEM advances.
2. **Branch**
   - ex_branch_taken & ex_v: if_id_flush=1, id_ex_flush=1, pc_write=1.
   - Next cycle: shadow ex_v=0, mem receives the branch.
   - Branch overrides load-use.
3. **Load-use**
   - id_valid & ex_v & ex_load & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
   - Effect: pc_write=0, if_id_write=0, id_ex_bubble=1; shadow ex_v loads 0.
4. **Otherwise**
   - pc_write=1, if_id_write=1, stage_en=1, all strobes 0.

Shadow advance, when stage_en=1:
- WB takes MEM.
- MEM takes EX.
- EX takes ID (valid = id_valid & ~bubble & ~flush).

Forwarding (per operand, EX rs vs shadow):
- MEM match takes precedence: mem_v & mem_regwrite & ~mem_load & mem_rd!=0 & mem_rd==rs → 10.
- Else WB match (same conditions minus ~load) → 01.
- Else 00.
- Operand mux selects per code. Unused operands (use flag 0) still forward; this is harmless.

A MEM-stage load matching an EX source is unreachable by construction and is flagged by a bench assertion.

Statistics counters saturate at all-ones:
- stall_count +1 per load-use cycle and per freeze cycle.
- flush_count +1 per branch flush.

## Timing
- Controls, forward selects and operands are combinational (same cycle). Shadow and counters update on the rising clock edge.
- Reset (asynchronous assert, synchronous-style deassert) clears all shadow v, lat_cnt and counters.
- Output values at reset: pc_write=1, if_id_write=1, stage_en=1, all strobes 0, forward_a/b=00, ex_op_a/b = ex_rs*_data.
- Load-use costs exactly 1 cycle. The consumer then forwards from WB (01).
- A load with MEM_LAT=N freezes for N-1 cycles. A branch held in EX during a freeze flushes on the first unfrozen cycle.
- Reset mid-freeze: freeze drops immediately and lat_cnt=0.

## Test plan
- **Reset:** hold reset_n=0, then release → pc_write=1, stage_en=1, counters 0, forward 00.
- **ALU forwarding:** `add x5,x1,x2` then `sub x6,x5,x3` → in sub's EX cycle forward_a=10, ex_op_a=mem_fwd_data; third-instruction use of x5 → 01.
- **Load-use:** `ld x6,8(x0)` then `add x7,x6,x1` → one cycle with pc_write=0, id_ex_bubble=1; next cycle forward_a=01; stall_count=1.
- **Branch taken:** ex_branch_taken=1 with ex_v → if_id_flush=id_ex_flush=1 for one cycle; next-cycle ex_v=0; flush_count=1.
- **MEM_LAT=3 load:**
  - Load in MEM → stage_en=0 and wb_bubble=1 for 2 cycles, then stage_en=1.
  - A taken branch in EX flushes only after the freeze.
  - Reset asserted mid-freeze → stage_en=1 immediately.
- **x0 and saturation:**
  - Write to x0 followed by a read of x0 → forward 00, no stall.
  - With CNT_W=2 and 5 stalls → stall_count=3.
